// File: rtl/ntt_pkg.sv
// ntt_pkg: shared mode enum, stage control struct and Barrett constant helpers.
package ntt_pkg;
  typedef enum logic {NTT_CT = 1'b0, NTT_GS = 1'b1} ntt_mode_e;
  typedef struct packed {
    logic      valid;
    ntt_mode_e mode;
  } ntt_stage_ctl_t;
  function automatic int barrett_k(input longint unsigned q);
    return $clog2(q);
  endfunction
  function automatic logic [127:0] barrett_mu(input longint unsigned q);
    return (128'd1 << (2 * barrett_k(q))) / 128'(q);
  endfunction
endpackage

// File: rtl/ntt_barrett_red.sv
// ntt_barrett_red: combinational Barrett reduction of a product below Q^2 into [0, Q).
module ntt_barrett_red
  import ntt_pkg::*;
#(
  parameter int          W = 32,
  parameter int unsigned Q = 40961
) (
  input  logic [2*W-1:0] i_x,
  output logic [W-1:0]   o_r
);
  localparam int K = barrett_k(64'(Q));
  localparam int PW = 2 * W + 4;
  localparam logic [PW-1:0] MU = PW'(barrett_mu(64'(Q)));
  localparam logic [PW-1:0] QP = PW'(Q);
  logic [PW-1:0] w_x, w_q, w_r0, w_r1, w_r2;
  // quotient estimate undershoots by at most 2, so two trial subtractions suffice
  always_comb begin
    w_x  = PW'(i_x);
    w_q  = ((w_x >> (K - 1)) * MU) >> (K + 1);
    w_r0 = w_x - w_q * QP;
    w_r1 = (w_r0 >= QP) ? w_r0 - QP : w_r0;
    w_r2 = (w_r1 >= QP) ? w_r1 - QP : w_r1;
  end
  assign o_r = W'(w_r2);
endmodule

// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe: 3-stage CT/GS modular butterfly with valid/ready and a global stall.
// Define NTT_BF_INTT_HALVE_EN to scale inverse-mode results by 2^-1 mod Q.
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int          W     = 32,
  parameter int unsigned Q     = 40961,
  parameter int          TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [W-1:0]     A_in,
  input  logic [W-1:0]     B_in,
  input  logic [W-1:0]     Wk_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     A_out,
  output logic [W-1:0]     B_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam logic [W:0] QE = (W + 1)'(Q);
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= QE) ? W'(s - QE) : W'(s);
  endfunction
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? W'({1'b0, a} + QE - {1'b0, b}) : a - b;
  endfunction
`ifdef NTT_BF_INTT_HALVE_EN
  function automatic logic [W-1:0] halve(input logic [W-1:0] x);
    logic [W:0] t;
    t = x[0] ? {1'b0, x} + QE : {1'b0, x};
    return W'(t >> 1);
  endfunction
`endif
  ntt_stage_ctl_t   r_c1, r_c2;
  logic             r_v3;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  logic [W-1:0]     r_x1, r_m1, r_w1, r_x2, r_a3, r_b3;
  logic [2*W-1:0]   r_p2;
  logic             w_en;
  logic [W-1:0]     w_red, w_add, w_sub, w_a3, w_b3;
  // the stall is global: every stage freezes while the output beat is refused
  assign w_en      = !(r_v3 && !out_ready);
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign busy      = r_c1.valid | r_c2.valid | r_v3;
  assign A_out     = r_a3;
  assign B_out     = r_b3;
  assign out_tag   = r_tag3;
  ntt_barrett_red #(.W(W), .Q(Q)) u_red (
    .i_x(r_p2),
    .o_r(w_red)
  );
  always_comb begin
    w_add = mod_add(r_x2, w_red);
    w_sub = mod_sub(r_x2, w_red);
`ifdef NTT_BF_INTT_HALVE_EN
    w_a3  = (r_c2.mode == NTT_GS) ? halve(r_x2) : w_add;
    w_b3  = (r_c2.mode == NTT_GS) ? halve(w_red) : w_sub;
`else
    w_a3  = (r_c2.mode == NTT_GS) ? r_x2 : w_add;
    w_b3  = (r_c2.mode == NTT_GS) ? w_red : w_sub;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c1   <= '0;
      r_c2   <= '0;
      r_v3   <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_x1   <= '0;
      r_m1   <= '0;
      r_w1   <= '0;
      r_x2   <= '0;
      r_p2   <= '0;
      r_a3   <= '0;
      r_b3   <= '0;
    end else if (w_en) begin
      r_c1.valid <= in_valid;
      r_c1.mode  <= ntt_mode_e'(in_mode);
      r_x1       <= in_mode ? mod_add(A_in, B_in) : A_in;
      r_m1       <= in_mode ? mod_sub(A_in, B_in) : B_in;
      r_w1       <= Wk_in;
      r_tag1     <= in_tag;
      r_c2       <= r_c1;
      r_x2       <= r_x1;
      r_p2       <= {{W{1'b0}}, r_m1} * {{W{1'b0}}, r_w1};
      r_tag2     <= r_tag1;
      r_v3       <= r_c2.valid;
      r_a3       <= w_a3;
      r_b3       <= w_b3;
      r_tag3     <= r_tag2;
    end
  end
endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// tb_ntt_butterfly_pipe: directed and streamed checks of the NTT butterfly pipeline (Q = 40961).
module tb_ntt_butterfly_pipe;
  localparam longint unsigned Q = 40961;
  logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, busy;
  logic [31:0] A_in = '0, B_in = '0, Wk_in = '0, A_out, B_out;
  logic [7:0]  in_tag = '0, out_tag;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  ntt_butterfly_pipe #(.W(32), .Q(40961), .TAG_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .A_in(A_in), .B_in(B_in), .Wk_in(Wk_in), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .A_out(A_out), .B_out(B_out), .out_tag(out_tag), .busy(busy)
  );
  function automatic logic [63:0] model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] w);
    longint unsigned ao, bo, t;
    if (!m) begin
      t  = (64'(b) * 64'(w)) % Q;
      ao = (64'(a) + t) % Q;
      bo = (64'(a) + Q - t) % Q;
    end else begin
      ao = (64'(a) + 64'(b)) % Q;
      bo = (((64'(a) + Q - 64'(b)) % Q) * 64'(w)) % Q;
    end
`ifdef NTT_BF_INTT_HALVE_EN
    if (m) begin
      ao = ao[0] ? (ao + Q) >> 1 : ao >> 1;
      bo = bo[0] ? (bo + Q) >> 1 : bo >> 1;
    end
`endif
    return {ao[31:0], bo[31:0]};
  endfunction
  function automatic logic [31:0] pick();
    int unsigned r;
    r = $urandom_range(0, 9);
    return (r == 0) ? 32'(Q - 1) : (r == 1) ? 32'd0 : 32'($urandom_range(0, 40960));
  endfunction
  task automatic do_beat(input logic m, input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                         input logic [7:0] tg, output logic [31:0] ao, output logic [31:0] bo,
                         output logic [7:0] to, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; A_in = a; B_in = b; Wk_in = w; in_tag = tg;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    ao = A_out; bo = B_out; to = out_tag;
  endtask
  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_err++; $display("FAIL reset_flags: got valid/busy/ready=%b want 001", {out_valid, busy, in_ready});
    end
    n_vec++;
    if ({A_out, B_out, out_tag} !== 72'd0) begin
      n_err++; $display("FAIL reset_data: got A=%0d B=%0d tag=%0d want 0 0 0", A_out, B_out, out_tag);
    end
    reset_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask
  task automatic test_fwd();
    logic [31:0] ao, bo; logic [7:0] to; int lat;
    do_beat(1'b0, 32'd5, 32'd3, 32'd2, 8'hA5, ao, bo, to, lat);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL fwd_latency: got %0d want 3", lat); end
    n_vec++;
    if ({ao, bo, to} !== {32'd11, 32'd40960, 8'hA5}) begin
      n_err++; $display("FAIL fwd_basic: got A=%0d B=%0d tag=%0h want 11 40960 a5", ao, bo, to);
    end
  endtask
  task automatic test_inv();
    logic [31:0] ao, bo, ea, eb; logic [7:0] to; int lat;
`ifdef NTT_BF_INTT_HALVE_EN
    ea = 32'd4; eb = 32'd2;
`else
    ea = 32'd8; eb = 32'd4;
`endif
    do_beat(1'b1, 32'd5, 32'd3, 32'd2, 8'h3C, ao, bo, to, lat);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL inv_latency: got %0d want 3", lat); end
    n_vec++;
    if ({ao, bo, to} !== {ea, eb, 8'h3C}) begin
      n_err++; $display("FAIL inv_basic: got A=%0d B=%0d tag=%0h want %0d %0d 3c", ao, bo, to, ea, eb);
    end
  endtask
  task automatic test_wrap();
    logic [31:0] ao, bo, ea, eb; logic [7:0] to; int lat;
    do_beat(1'b0, 32'd40960, 32'd1, 32'd1, 8'h01, ao, bo, to, lat);
    n_vec++;
    if ({ao, bo} !== {32'd0, 32'd40959}) begin
      n_err++; $display("FAIL fwd_wrap: got A=%0d B=%0d want 0 40959", ao, bo);
    end
`ifdef NTT_BF_INTT_HALVE_EN
    ea = 32'd20482; eb = 32'd20482;
`else
    ea = 32'd3; eb = 32'd3;
`endif
    do_beat(1'b1, 32'd3, 32'd0, 32'd1, 8'h02, ao, bo, to, lat);
    n_vec++;
    if ({ao, bo} !== {ea, eb}) begin
      n_err++; $display("FAIL inv_wrap: got A=%0d B=%0d want %0d %0d", ao, bo, ea, eb);
    end
  endtask
  task automatic test_max_product();
    logic [31:0] ao, bo, ea, eb; logic [7:0] to; int lat;
    do_beat(1'b0, 32'd0, 32'd40960, 32'd40960, 8'h10, ao, bo, to, lat);
    n_vec++;
    if ({ao, bo} !== {32'd1, 32'd40960}) begin
      n_err++; $display("FAIL fwd_maxprod: got A=%0d B=%0d want 1 40960", ao, bo);
    end
`ifdef NTT_BF_INTT_HALVE_EN
    ea = 32'd20480; eb = 32'd20481;
`else
    ea = 32'd40960; eb = 32'd1;
`endif
    do_beat(1'b1, 32'd40960, 32'd0, 32'd40960, 8'h11, ao, bo, to, lat);
    n_vec++;
    if ({ao, bo} !== {ea, eb}) begin
      n_err++; $display("FAIL inv_maxprod: got A=%0d B=%0d want %0d %0d", ao, bo, ea, eb);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++; $display("FAIL idle_after_drain: got busy/valid=%b want 00", {busy, out_valid});
    end
  endtask
  task automatic test_back_to_back();
    logic [63:0] eq[$]; logic [7:0] tq[$]; logic [63:0] ev; logic [7:0] tv;
    int sent = 0, got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_mode = sent[0]; A_in = 32'(1000 * sent + 7); B_in = 32'(40960 - 333 * sent);
        Wk_in = 32'(12345 + 1111 * sent); in_tag = sent[7:0];
      end
      #1;
      n_vec++;
      if (in_ready !== !(c >= 4 && c <= 6)) begin
        n_err++; $display("FAIL b2b_ready cycle %0d: got %b want %b", c, in_ready, !(c >= 4 && c <= 6));
      end
      if (out_valid && out_ready) begin
        n_vec++; got++;
        if (eq.size() == 0) begin
          n_err++; $display("FAIL b2b_extra_beat: got tag %0d want none", out_tag);
        end else begin
          ev = eq.pop_front(); tv = tq.pop_front();
          if ({A_out, B_out, out_tag} !== {ev, tv}) begin
            n_err++; $display("FAIL b2b_data: got A=%0d B=%0d tag=%0d want %0d %0d %0d",
                              A_out, B_out, out_tag, ev[63:32], ev[31:0], tv);
          end
        end
      end
      if (in_valid && in_ready) begin
        eq.push_back(model(in_mode, A_in, B_in, Wk_in)); tq.push_back(in_tag); sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (got !== 8 || eq.size() != 0) begin
      n_err++; $display("FAIL b2b_count: got %0d delivered, %0d pending want 8, 0", got, eq.size());
    end
  endtask
  task automatic test_mid_reset();
    int stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = i[0]; A_in = 32'(i + 1); B_in = 32'd2; Wk_in = 32'd3; in_tag = 8'(i + 40);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, busy} !== 2'b11) begin
      n_err++; $display("FAIL midrst_loaded: got valid/busy=%b want 11", {out_valid, busy});
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, busy, in_ready, A_out, B_out, out_tag} !== {3'b001, 72'd0}) begin
      n_err++; $display("FAIL midrst_async: got valid=%b busy=%b ready=%b A=%0d B=%0d tag=%0d want 0 0 1 0 0 0",
                        out_valid, busy, in_ready, A_out, B_out, out_tag);
    end
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    n_vec++;
    if (stale !== 0) begin n_err++; $display("FAIL midrst_stale: got %0d active cycles want 0", stale); end
  endtask
  task automatic test_random();
    logic [63:0] eq[$]; logic [7:0] tq[$]; logic [63:0] ev; logic [7:0] tv;
    logic hold = 1'b0; logic [71:0] held = '0;
    for (int i = 0; i < 4000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_mode = 1'($urandom_range(0, 1)); A_in = pick(); B_in = pick(); Wk_in = pick();
      in_tag = 8'($urandom_range(0, 255));
      #1;
      if (hold) begin
        n_vec++;
        if ({out_valid, A_out, B_out, out_tag} !== {1'b1, held}) begin
          n_err++; $display("FAIL rnd_stall_hold cycle %0d: got A=%0d B=%0d tag=%0d want %0d %0d %0d",
                            i, A_out, B_out, out_tag, held[71:40], held[39:8], held[7:0]);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (eq.size() == 0) begin
          n_err++; $display("FAIL rnd_extra_beat: got tag %0d want none", out_tag);
        end else begin
          ev = eq.pop_front(); tv = tq.pop_front();
          if ({A_out, B_out, out_tag} !== {ev, tv} || A_out >= 32'(Q) || B_out >= 32'(Q)) begin
            n_err++; $display("FAIL rnd_data cycle %0d: got A=%0d B=%0d tag=%0d want %0d %0d %0d",
                              i, A_out, B_out, out_tag, ev[63:32], ev[31:0], tv);
          end
        end
      end
      hold = out_valid && !out_ready;
      held = {A_out, B_out, out_tag};
      if (in_valid && in_ready) begin
        eq.push_back(model(in_mode, A_in, B_in, Wk_in)); tq.push_back(in_tag);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && eq.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        n_vec++;
        ev = eq.pop_front(); tv = tq.pop_front();
        if ({A_out, B_out, out_tag} !== {ev, tv}) begin
          n_err++; $display("FAIL rnd_drain: got A=%0d B=%0d tag=%0d want %0d %0d %0d",
                            A_out, B_out, out_tag, ev[63:32], ev[31:0], tv);
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (eq.size() != 0) begin n_err++; $display("FAIL rnd_lost: got %0d undelivered want 0", eq.size()); end
  endtask
  initial begin
    test_reset();
    test_fwd();
    test_inv();
    test_wrap();
    test_max_product();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
